// File: rtl/pwm_period_latch_pkg.sv
// Shared definitions for the PWM period/latch stage and the on-time stage it feeds.
// Holds the FSM state encoding and the default counter widths.
package pwm_period_latch_pkg;

  localparam int CNT_W_DEFAULT = 21;
  localparam int DT_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns the PWM latch into complementary pwm_h/pwm_l with a
// programmable both-low gap after every latch edge. Fed with next-state latch/run values.
module pwm_deadtime
  import pwm_period_latch_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic            latch_i,
  input  logic [DT_W-1:0] dead_time_i,
  output logic            pwm_h_o,
  output logic            pwm_l_o
);

  logic            lat_q;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_h_d, pwm_l_d;

  // cnt_d is the number of cycles the latch has already held its new value; it
  // saturates so a long-stable latch never wraps back under dead_time.
  always_comb begin
    if (latch_i != lat_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + DT_W'(1);
    end
    pwm_h_d = run_i &&  latch_i && (cnt_d >= dead_time_i);
    pwm_l_d = run_i && !latch_i && (cnt_d >= dead_time_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q   <= 1'b0;
      cnt_q   <= '1;
      pwm_h_o <= 1'b0;
      pwm_l_o <= 1'b0;
    end else begin
      lat_q   <= latch_i;
      cnt_q   <= cnt_d;
      pwm_h_o <= pwm_h_d;
      pwm_l_o <= pwm_l_d;
    end
  end

endmodule

// File: rtl/pwm_period_latch.sv
// Period timer, IDLE/ON/OFF FSM and SR latch for the high-side PWM output.
// Define PWM_DEADTIME_EN to add the complementary low-side output with dead time.
module pwm_period_latch
  import pwm_period_latch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DT_W  = DT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period_time,
  input  logic [CNT_W-1:0] max_on_time,
  input  logic [DT_W-1:0]  dead_time,
  input  logic             reset_pwm,
  output logic             set,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             fault_maxduty
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             set_d, fault_d, latch_d;
  logic [CNT_W-1:0] period_eff;
  logic             wrap, max_hit;

  assign period_eff = (period_time < CNT_W'(2)) ? CNT_W'(2) : period_time;
  assign wrap       = (pcnt_q == period_q - CNT_W'(1));
  assign max_hit    = (max_on_time != '0) && (ocnt_q == max_on_time - CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    ocnt_d   = ocnt_q;
    period_d = period_q;
    set_d    = 1'b0;
    fault_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
      ocnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_ON;
          pcnt_d   = '0;
          ocnt_d   = '0;
          period_d = period_eff;
          set_d    = 1'b1;
        end
        ST_ON: begin
          // A period start outranks both termination causes: the pulse simply restarts.
          if (wrap) begin
            pcnt_d   = '0;
            ocnt_d   = '0;
            period_d = period_eff;
            set_d    = 1'b1;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            ocnt_d = ocnt_q + CNT_W'(1);
            if (max_hit) begin
              state_d = ST_OFF;
              fault_d = 1'b1;
            end else if (reset_pwm) begin
              state_d = ST_OFF;
            end
          end
        end
        ST_OFF: begin
          if (wrap) begin
            state_d  = ST_ON;
            pcnt_d   = '0;
            ocnt_d   = '0;
            period_d = period_eff;
            set_d    = 1'b1;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    latch_d = (state_d == ST_ON);
  end

  // NOTE: sequential state uses non-blocking assignments only; all comb results above
  // are consumed here in one clocked step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pcnt_q        <= '0;
      ocnt_q        <= '0;
      period_q      <= CNT_W'(2);
      set           <= 1'b0;
      fault_maxduty <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      ocnt_q        <= ocnt_d;
      period_q      <= period_d;
      set           <= set_d;
      fault_maxduty <= fault_d;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic run_d;
  assign run_d = (state_d != ST_IDLE);

  pwm_deadtime #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_d),
    .latch_i     (latch_d),
    .dead_time_i (dead_time),
    .pwm_h_o     (pwm_h),
    .pwm_l_o     (pwm_l)
  );
`else
  logic latch_q;
  logic unused_dt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign pwm_h     = latch_q;
  assign pwm_l     = 1'b0;
  assign unused_dt = ^dead_time;
`endif

endmodule

// File: tb/tb_pwm_period_latch.sv
// Scoreboard bench for pwm_period_latch: a period/phase reference model predicts each
// cycle's outputs, a monitor compares them against the DUT.
module tb_pwm_period_latch;

  localparam int CNT_W = 21;
  localparam int DT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             reset_pwm = 1'b0;
  logic [CNT_W-1:0] period_time = '0;
  logic [CNT_W-1:0] max_on_time = '0;
  logic [DT_W-1:0]  dead_time = '0;
  logic             set, pwm_h, pwm_l, fault_maxduty;

  always #5 clk = ~clk;

  pwm_period_latch #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .period_time   (period_time),
    .max_on_time   (max_on_time),
    .dead_time     (dead_time),
    .reset_pwm     (reset_pwm),
    .set           (set),
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .fault_maxduty (fault_maxduty)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  // Stimulus knobs; resp_ontime > 0 emulates the on-time stage, 0 never strobes, < 0 random.
  int g_pt = 10, g_mx = 0, g_dt = 0, resp_ontime = 0;

  // Reference model: is a period running, cycles since period start, period length,
  // whether the pulse is still high, and how long the latch has held its value.
  bit m_run, m_high, m_set, m_fault, m_prev;
  int m_phase, m_per, m_stable;

  logic [3:0] exp_q[$];
  int c_set, c_h, c_l, c_f, c_both;

  function automatic int eff_period(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_high = 0; m_set = 0; m_fault = 0;
    m_phase = 0; m_per = 2; m_prev = 0; m_stable = 1000;
  endtask

  task automatic model_step(input bit en_v, input bit rstn_v, input bit rp);
    bit h, l;
    if (!rstn_v) begin
      model_reset();
    end else begin
      if (!en_v) begin
        m_run = 0; m_phase = 0; m_high = 0; m_set = 0; m_fault = 0;
      end else if (!m_run || m_phase == m_per - 1) begin
        m_run = 1; m_phase = 0; m_per = eff_period(g_pt);
        m_high = 1; m_set = 1; m_fault = 0;
      end else begin
        m_phase++;
        m_set = 0; m_fault = 0;
        if (m_high) begin
          if (g_mx != 0 && m_phase == g_mx) begin
            m_high = 0; m_fault = 1;
          end else if (rp) begin
            m_high = 0;
          end
        end
      end
      if (m_high == m_prev) m_stable = (m_stable < 1000) ? m_stable + 1 : 1000;
      else m_stable = 1;
      m_prev = m_high;
    end
`ifdef PWM_DEADTIME_EN
    h = m_run &&  m_high && (m_stable >= g_dt + 1);
    l = m_run && !m_high && (m_stable >= g_dt + 1);
`else
    h = m_high;
    l = 1'b0;
`endif
    exp_q.push_back({m_set, h, l, m_fault});
  endtask

  task automatic step(input bit en_v, input bit rstn_v);
    @(negedge clk);
    rst_n       = rstn_v;
    en          = en_v;
    period_time = CNT_W'(g_pt);
    max_on_time = CNT_W'(g_mx);
    dead_time   = DT_W'(g_dt);
    if (resp_ontime < 0) reset_pwm = ($urandom_range(0, 4) == 0);
    else reset_pwm = (resp_ontime > 0) && m_high && (m_phase == resp_ontime - 1);
    model_step(en_v, rstn_v, reset_pwm);
  endtask

  task automatic run(input int n, input bit en_v);
    repeat (n) step(en_v, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    c_set = 0; c_h = 0; c_l = 0; c_f = 0; c_both = 0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", {28'd0, set, pwm_h, pwm_l, fault_maxduty}, 32'd0);
  endtask

  // Monitor: compares the DUT against the queued prediction once per cycle.
  initial begin
    int cyc;
    logic [3:0] e;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d {set,h,l,fault}", cyc),
              {28'd0, set, pwm_h, pwm_l, fault_maxduty}, {28'd0, e});
      end
      c_set  += int'(set);
      c_h    += int'(pwm_h);
      c_l    += int'(pwm_l);
      c_f    += int'(fault_maxduty);
      c_both += int'(pwm_h & pwm_l);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    run(3, 1'b0);

    // Basic run: on-time stage answers 4 cycles after set.
    g_pt = 10; g_mx = 0; resp_ontime = 5;
    settle(); clear_counts();
    run(50, 1'b1);
    settle();
    check("basic_set_count", c_set, 5);
    check("basic_high_cycles", c_h, 25);
    check("basic_fault_count", c_f, 0);
    run(3, 1'b0);

    // Max duty cap terminates every pulse.
    g_pt = 10; g_mx = 6; resp_ontime = 0;
    settle(); clear_counts();
    run(50, 1'b1);
    settle();
    check("maxduty_set_count", c_set, 5);
    check("maxduty_high_cycles", c_h, 30);
    check("maxduty_fault_count", c_f, 5);
    run(3, 1'b0);

    // Pulse never terminated: pwm_h stays high through every wrap.
    g_pt = 5; g_mx = 0; resp_ontime = 0;
    settle(); clear_counts();
    run(40, 1'b1);
    settle();
    check("overlap_set_count", c_set, 8);
    check("overlap_high_cycles", c_h, 40);
    run(3, 1'b0);

    // en dropped at pcnt=3, then re-enabled.
    g_pt = 10;
    settle(); clear_counts();
    run(4, 1'b1);
    run(3, 1'b0);
    run(5, 1'b1);
    settle();
    check("en_drop_set_count", c_set, 2);
    check("en_drop_high_cycles", c_h, 9);

    // Async reset mid-ON; release with en low stays idle.
    run(3, 1'b0);
    run(3, 1'b1);
    async_reset();
    repeat (2) step(1'b1, 1'b0);
    settle(); clear_counts();
    run(4, 1'b0);
    settle();
    check("post_reset_idle_set", c_set, 0);
    check("post_reset_idle_high", c_h, 0);
    run(3, 1'b1);

`ifdef PWM_DEADTIME_EN
    run(3, 1'b0);
    g_pt = 20; g_mx = 0; g_dt = 2; resp_ontime = 8;
    settle(); clear_counts();
    run(40, 1'b1);
    settle();
    check("dt_high_cycles", c_h, 12);
    check("dt_low_cycles", c_l, 20);
    check("dt_overlap", c_both, 0);
    run(3, 1'b0);
    resp_ontime = 1;
    settle(); clear_counts();
    run(40, 1'b1);
    settle();
    check("dt_short_high", c_h, 0);
    check("dt_short_low", c_l, 34);
    check("dt_short_overlap", c_both, 0);
`endif

    // Randomized traffic against the reference model.
    resp_ontime = -1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) g_pt = $urandom_range(0, 12);
      if ($urandom_range(0, 39) == 0) g_mx = $urandom_range(0, 9);
`ifdef PWM_DEADTIME_EN
      if ($urandom_range(0, 59) == 0) g_dt = $urandom_range(0, 4);
`endif
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        step(1'b1, 1'b0);
      end
      step($urandom_range(0, 49) != 0, 1'b1);
    end

    settle();
    settle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
